// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the CPU clock controller.
package clk_ctrl_pkg;

    localparam int unsigned TICK_DIV_DEFAULT = 20000;

    typedef enum logic [1:0] {
        ST_HALT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_ARM  = 2'd2,
        ST_STEP_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_clock_ctrl_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clk cycles.
module tick_gen
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned   CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..TICK_DIV-1 and wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable controller: run/halt/single-step FSM with cycle counter.
module cpu_clock_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_req,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        bp_hit,
    input  logic        cnt_clr,
    output logic        cpu_ce,
    output logic        halted,
    output logic        step_ack,
    output logic [31:0] cycle_cnt
);

    state_t      state, state_nx;
    logic        tick;
    logic        step_q;
    logic        step_edge;
    logic        ce_nx;
    logic [31:0] cnt_q;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign step_edge = step_req & ~step_q;

    // Step request edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            step_q <= 1'b0;
        else
            step_q <= step_req;
    end

    // State register plus registered decodes so halted/step_ack never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_HALT;
            cpu_ce   <= 1'b0;
            halted   <= 1'b1;
            step_ack <= 1'b0;
        end else begin
            state    <= state_nx;
            cpu_ce   <= ce_nx;
            halted   <= (state_nx == ST_HALT);
            step_ack <= (state_nx == ST_STEP_DONE);
        end
    end

    // Next-state and clock-enable decision; halt requests beat ticks.
    always_comb begin
        state_nx = state;
        ce_nx    = 1'b0;
        case (state)
            ST_HALT: begin
                if (halt_req || bp_hit)
                    state_nx = ST_HALT;
                else if (run_req)
                    state_nx = ST_RUN;
                else if (step_edge)
                    state_nx = ST_STEP_ARM;
            end
            ST_RUN: begin
                if (halt_req || bp_hit)
                    state_nx = ST_HALT;
                else
                    ce_nx = tick;
            end
            ST_STEP_ARM: begin
                if (halt_req)
                    state_nx = ST_HALT;
                else if (tick) begin
                    state_nx = ST_STEP_DONE;
                    ce_nx    = 1'b1;
                end
            end
            ST_STEP_DONE: state_nx = ST_HALT;
            default:      state_nx = ST_HALT;
        endcase
    end

    // Count issued CPU cycles; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (cnt_clr)
            cnt_q <= '0;
        else if (cpu_ce)
            cnt_q <= cnt_q + 32'd1;
    end

    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed testbench for cpu_clock_ctrl with TICK_DIV=4.
module tb_cpu_clock_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_req, halt_req, step_req, bp_hit, cnt_clr;
    logic        cpu_ce, halted, step_ack;
    logic [31:0] cycle_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    cpu_clock_ctrl #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run_req   (run_req),
        .halt_req  (halt_req),
        .step_req  (step_req),
        .bp_hit    (bp_hit),
        .cnt_clr   (cnt_clr),
        .cpu_ce    (cpu_ce),
        .halted    (halted),
        .step_ack  (step_ack),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic adv(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Edge numbers in comments count rising edges since the first reset release.
    initial begin
        rst = 1'b1; run_req = 1'b0; halt_req = 1'b0;
        step_req = 1'b0; bp_hit = 1'b0; cnt_clr = 1'b0;
        adv(2);
        chk("rst_ce", {31'd0, cpu_ce}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_ack", {31'd0, step_ack}, 32'd0);
        chk("rst_cnt", cycle_cnt, 32'd0);

        // Free run: pulses after edges 4,8,...,20
        rst = 1'b0; run_req = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            adv(1);
            chk("run_ce", {31'd0, cpu_ce}, (i % 4 == 0) ? 32'd1 : 32'd0);
            if (i == 1) chk("run_halted", {31'd0, halted}, 32'd0);
        end
        chk("run_cnt5", cycle_cnt, 32'd5);

        // Halt in the tick cycle (after edge 23)
        adv(2);
        halt_req = 1'b1;
        adv(1); // edge 24
        chk("halt_tick_ce", {31'd0, cpu_ce}, 32'd0);
        chk("halt_tick_halted", {31'd0, halted}, 32'd1);
        chk("halt_tick_cnt", cycle_cnt, 32'd5);
        halt_req = 1'b0; run_req = 1'b0; step_req = 1'b1;

        // Single step
        adv(1); // 25: STEP_ARM
        chk("step_arm_halted", {31'd0, halted}, 32'd0);
        chk("step_arm_ce", {31'd0, cpu_ce}, 32'd0);
        adv(2); // 27
        chk("step_wait_ce", {31'd0, cpu_ce}, 32'd0);
        adv(1); // 28: STEP_DONE
        chk("step_ce", {31'd0, cpu_ce}, 32'd1);
        chk("step_ack", {31'd0, step_ack}, 32'd1);
        adv(1); // 29
        chk("step_end_ce", {31'd0, cpu_ce}, 32'd0);
        chk("step_end_ack", {31'd0, step_ack}, 32'd0);
        chk("step_end_halted", {31'd0, halted}, 32'd1);
        chk("step_cnt6", cycle_cnt, 32'd6);
        for (int i = 0; i < 20; i++) begin // 30..49, step_req still high
            adv(1);
            chk("step_hold_ce", {31'd0, cpu_ce}, 32'd0);
            chk("step_hold_halted", {31'd0, halted}, 32'd1);
            chk("step_hold_ack", {31'd0, step_ack}, 32'd0);
        end
        step_req = 1'b0;

        // Breakpoint beats run_req
        bp_hit = 1'b1; run_req = 1'b1;
        for (int i = 0; i < 8; i++) begin // 50..57
            adv(1);
            chk("bp_halted", {31'd0, halted}, 32'd1);
            chk("bp_ce", {31'd0, cpu_ce}, 32'd0);
        end
        bp_hit = 1'b0;
        adv(1); // 58
        chk("bp_resume_halted", {31'd0, halted}, 32'd0);
        adv(1); // 59
        chk("resume_ce0", {31'd0, cpu_ce}, 32'd0);
        adv(1); // 60
        chk("resume_ce1", {31'd0, cpu_ce}, 32'd1);
        adv(1); // 61
        chk("resume_cnt7", cycle_cnt, 32'd7);

        // Clear coincident with cpu_ce
        adv(3); // 64
        chk("clr_ce", {31'd0, cpu_ce}, 32'd1);
        cnt_clr = 1'b1;
        adv(1); // 65
        chk("clr_prio", cycle_cnt, 32'd0);
        cnt_clr = 1'b0;
        adv(4); // 69
        chk("clr_then_inc", cycle_cnt, 32'd1);
        halt_req = 1'b1;
        adv(1); // 70
        chk("halt_again", {31'd0, halted}, 32'd1);
        halt_req = 1'b0; run_req = 1'b0;

        // Counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        adv(1); // 71
        chk("wrap_preload", cycle_cnt, 32'hFFFF_FFFF);
        step_req = 1'b1;
        adv(1); // 72
        chk("wrap_arm", {31'd0, halted}, 32'd0);
        adv(4); // 76
        chk("wrap_ce", {31'd0, cpu_ce}, 32'd1);
        chk("wrap_before", cycle_cnt, 32'hFFFF_FFFF);
        adv(1); // 77
        chk("wrap_zero", cycle_cnt, 32'd0);
        chk("wrap_halted", {31'd0, halted}, 32'd1);
        step_req = 1'b0;

        // Reset during STEP_ARM
        adv(1); // 78
        step_req = 1'b1;
        adv(1); // 79: STEP_ARM
        chk("rst_arm_pre", {31'd0, halted}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_arm_ce", {31'd0, cpu_ce}, 32'd0);
        chk("rst_arm_ack", {31'd0, step_ack}, 32'd0);
        chk("rst_arm_halted", {31'd0, halted}, 32'd1);
        adv(2);
        step_req = 1'b0; rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            adv(1);
            chk("post_rst_ce", {31'd0, cpu_ce}, 32'd0);
            chk("post_rst_ack", {31'd0, step_ack}, 32'd0);
            chk("post_rst_halted", {31'd0, halted}, 32'd1);
            chk("post_rst_cnt", cycle_cnt, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
